// File: rtl/jc_pkg.sv
// Shared types and constants for the Johnson-code decoder slice.
package jc_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } jc_state_e;

    localparam int ERRCNT_W = 8;

    // Width of a phase index for a code of the given width (sequence length 2*width).
    function automatic int idx_width(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/jc_code_decode.sv
// Combinational Johnson-code checker: flags legality and maps a legal code to its phase index.
module jc_code_decode import jc_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]            in,
    output logic                        legal,
    output logic [idx_width(WIDTH)-1:0] index
);

    localparam int IW = idx_width(WIDTH);

    logic [WIDTH-1:0] nxt_s;
    logic [WIDTH-1:0] diff_s;
    logic [IW:0]      pop_in_s;
    logic [IW:0]      pop_diff_s;

    assign nxt_s  = {in[WIDTH-2:0], ~in[WIDTH-1]};
    assign diff_s = in ^ nxt_s;

    // Population counts of the code and of its distance to the successor.
    always_comb begin
        pop_in_s   = {(IW+1){1'b0}};
        pop_diff_s = {(IW+1){1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            pop_in_s   = pop_in_s   + {{IW{1'b0}}, in[i]};
            pop_diff_s = pop_diff_s + {{IW{1'b0}}, diff_s[i]};
        end
    end

    // A Johnson code differs from its successor in exactly one bit; the upper half counts down.
    always_comb begin
        legal = (pop_diff_s == (IW+1)'(1));
        if (in[WIDTH-1] == 1'b0) begin
            index = pop_in_s[IW-1:0];
        end else begin
            index = IW'((IW+1)'(2 * WIDTH) - pop_in_s);
        end
    end

endmodule

// File: rtl/jc_decoder.sv
// Johnson-code receive checker: decode, successor check, HUNT/SYNC/LOCK tracking, error count.
// Optional feature macro: JC_DECODER_ERRCNT_EN builds the saturating err_cnt register.
module jc_decoder import jc_pkg::*; #(
    parameter int WIDTH    = 16,
    parameter int LOCK_LEN = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            in,
    input  logic                        in_valid,
    output logic [idx_width(WIDTH)-1:0] count,
    output logic                        count_valid,
    output logic                        illegal,
    output logic                        seq_err,
    output logic                        locked,
    output logic [ERRCNT_W-1:0]         err_cnt
);

    localparam int IW = idx_width(WIDTH);
    localparam int MW = $clog2(LOCK_LEN + 1);

    jc_state_e       state_r, state_nxt_s;
    logic [IW-1:0]   prev_r, prev_nxt_s, prev_succ_s;
    logic [MW-1:0]   match_r, match_nxt_s;
    logic            legal_s, in_seq_s;
    logic [IW-1:0]   index_s;
    logic [IW-1:0]   count_r, count_nxt_s;
    logic            count_valid_r, illegal_r, seq_err_r, locked_r;
    logic            count_valid_nxt_s, illegal_nxt_s, seq_err_nxt_s;

    jc_code_decode #(.WIDTH(WIDTH)) u_dec (
        .in    (in),
        .legal (legal_s),
        .index (index_s)
    );

    assign prev_succ_s = (prev_r == IW'(2 * WIDTH - 1)) ? {IW{1'b0}} : prev_r + IW'(1);
    assign in_seq_s    = (index_s == prev_succ_s);

    // State, sequence tracking and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= HUNT;
            prev_r        <= {IW{1'b0}};
            match_r       <= {MW{1'b0}};
            count_r       <= {IW{1'b0}};
            count_valid_r <= 1'b0;
            illegal_r     <= 1'b0;
            seq_err_r     <= 1'b0;
            locked_r      <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            prev_r        <= prev_nxt_s;
            match_r       <= match_nxt_s;
            count_r       <= count_nxt_s;
            count_valid_r <= count_valid_nxt_s;
            illegal_r     <= illegal_nxt_s;
            seq_err_r     <= seq_err_nxt_s;
            locked_r      <= (state_nxt_s == LOCK);
        end
    end

    // Next-state logic; nothing moves on cycles without in_valid.
    always_comb begin
        state_nxt_s = state_r;
        prev_nxt_s  = prev_r;
        match_nxt_s = match_r;
        if (!in_valid) begin
            state_nxt_s = state_r;
        end else if (!legal_s) begin
            state_nxt_s = HUNT;
            match_nxt_s = {MW{1'b0}};
        end else begin
            prev_nxt_s = index_s;
            case (state_r)
                HUNT: begin
                    match_nxt_s = MW'(1);
                    state_nxt_s = (LOCK_LEN == 1) ? LOCK : SYNC;
                end
                SYNC: begin
                    if (!in_seq_s) begin
                        match_nxt_s = MW'(1);
                    end else if ((int'(match_r) + 1) >= LOCK_LEN) begin
                        match_nxt_s = MW'(LOCK_LEN);
                        state_nxt_s = LOCK;
                    end else begin
                        match_nxt_s = match_r + MW'(1);
                    end
                end
                LOCK: begin
                    if (in_seq_s) begin
                        state_nxt_s = LOCK;
                    end else begin
                        state_nxt_s = SYNC;
                        match_nxt_s = MW'(1);
                    end
                end
                default: begin
                    state_nxt_s = HUNT;
                    match_nxt_s = {MW{1'b0}};
                end
            endcase
        end
    end

    // Output next-values; a repeated or skipped code only counts as seq_err while locked.
    always_comb begin
        count_valid_nxt_s = in_valid & legal_s;
        illegal_nxt_s     = in_valid & ~legal_s;
        seq_err_nxt_s     = in_valid & legal_s & (state_r == LOCK) & ~in_seq_s;
        if (count_valid_nxt_s) begin
            count_nxt_s = index_s;
        end else begin
            count_nxt_s = count_r;
        end
    end

    assign count       = count_r;
    assign count_valid = count_valid_r;
    assign illegal     = illegal_r;
    assign seq_err     = seq_err_r;
    assign locked      = locked_r;

`ifdef JC_DECODER_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_r;

    // Saturating error counter, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_r <= {ERRCNT_W{1'b0}};
        end else if ((illegal_nxt_s | seq_err_nxt_s) && (err_cnt_r != {ERRCNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + ERRCNT_W'(1);
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`else
    assign err_cnt = {ERRCNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_jc_decoder.sv
// Directed self-checking bench for jc_decoder with hand-computed expectations.
module tb_jc_decoder;

`ifdef JC_DECODER_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] code;
    logic        in_valid;
    logic [4:0]  count;
    logic        count_valid;
    logic        illegal;
    logic        seq_err;
    logic        locked;
    logic [7:0]  err_cnt;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    jc_decoder #(.WIDTH(16), .LOCK_LEN(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (code),
        .in_valid    (in_valid),
        .count       (count),
        .count_valid (count_valid),
        .illegal     (illegal),
        .seq_err     (seq_err),
        .locked      (locked),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle between edges, then sample just after the rising edge.
    task automatic step(input logic [15:0] c, input logic v);
        @(negedge clk);
        code     = c;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_err(input int n);
        return ERR_EN ? 8'(n) : 8'd0;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_cv"}, 32'(count_valid), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
        chk({tag, "_seqerr"}, 32'(seq_err), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_errcnt"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        logic [15:0] c;
        int idx;
        reset    = 1'b0;
        code     = 16'h0000;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Acquire lock on 0,1,2.
        step(16'h0000, 1'b1);
        chk("acq0_count", 32'(count), 32'd0);
        chk("acq0_cv", 32'(count_valid), 32'd1);
        chk("acq0_locked", 32'(locked), 32'd0);
        step(16'h0001, 1'b1);
        chk("acq1_count", 32'(count), 32'd1);
        chk("acq1_locked", 32'(locked), 32'd0);
        step(16'h0003, 1'b1);
        chk("acq2_count", 32'(count), 32'd2);
        chk("acq2_locked", 32'(locked), 32'd1);

        // Free run through the upper half and the 31->0 wrap.
        c   = 16'h0003;
        idx = 2;
        for (int k = 0; k < 30; k++) begin
            c   = {c[14:0], ~c[15]};
            idx = (idx + 1) % 32;
            step(c, 1'b1);
            chk("run_count", 32'(count), 32'(idx));
            chk("run_seqerr", 32'(seq_err), 32'd0);
            chk("run_locked", 32'(locked), 32'd1);
        end
        chk("run_end_code", 32'(c), 32'h0000);
        chk("run_errcnt", 32'(err_cnt), 32'd0);

        // Illegal code while locked.
        step(16'h0001, 1'b1);
        step(16'h0003, 1'b1);
        step(16'h0005, 1'b1);
        chk("ill_illegal", 32'(illegal), 32'd1);
        chk("ill_seqerr", 32'(seq_err), 32'd0);
        chk("ill_locked", 32'(locked), 32'd0);
        chk("ill_count", 32'(count), 32'd2);
        chk("ill_cv", 32'(count_valid), 32'd0);
        chk("ill_errcnt", 32'(err_cnt), 32'(exp_err(1)));
        step(16'h0007, 1'b1);
        chk("ill_pulse", 32'(illegal), 32'd0);
        chk("ill_r1_locked", 32'(locked), 32'd0);
        step(16'h000F, 1'b1);
        chk("ill_r2_locked", 32'(locked), 32'd0);
        step(16'h001F, 1'b1);
        chk("ill_relock", 32'(locked), 32'd1);
        chk("ill_relock_count", 32'(count), 32'd5);

        // Skip from index 6 to 8 while locked.
        step(16'h003F, 1'b1);
        step(16'h00FF, 1'b1);
        chk("skip_seqerr", 32'(seq_err), 32'd1);
        chk("skip_illegal", 32'(illegal), 32'd0);
        chk("skip_locked", 32'(locked), 32'd0);
        chk("skip_count", 32'(count), 32'd8);
        chk("skip_errcnt", 32'(err_cnt), 32'(exp_err(2)));
        step(16'h01FF, 1'b1);
        chk("skip_pulse", 32'(seq_err), 32'd0);
        chk("skip_r1_locked", 32'(locked), 32'd0);
        step(16'h03FF, 1'b1);
        chk("skip_relock", 32'(locked), 32'd1);

        // Repeated code is out of sequence.
        step(16'h03FF, 1'b1);
        chk("rep_seqerr", 32'(seq_err), 32'd1);
        chk("rep_locked", 32'(locked), 32'd0);
        chk("rep_errcnt", 32'(err_cnt), 32'(exp_err(3)));
        step(16'h07FF, 1'b1);
        step(16'h0FFF, 1'b1);
        chk("rep_relock", 32'(locked), 32'd1);
        chk("rep_count", 32'(count), 32'd12);

        // Valid gaps: garbage on the bus must be ignored.
        step(16'h1FFF, 1'b1);
        for (int g = 0; g < 3; g++) begin
            step(16'h0005, 1'b0);
            chk("gap3_cv", 32'(count_valid), 32'd0);
            chk("gap3_count", 32'(count), 32'd13);
            chk("gap3_illegal", 32'(illegal), 32'd0);
            chk("gap3_locked", 32'(locked), 32'd1);
        end
        step(16'h3FFF, 1'b1);
        chk("gap_a_cv", 32'(count_valid), 32'd1);
        chk("gap_a_count", 32'(count), 32'd14);
        step(16'h0000, 1'b0);
        chk("gap1_cv", 32'(count_valid), 32'd0);
        step(16'h7FFF, 1'b1);
        chk("gap_b_count", 32'(count), 32'd15);
        for (int g = 0; g < 5; g++) begin
            step(16'hABCD, 1'b0);
            chk("gap5_cv", 32'(count_valid), 32'd0);
        end
        step(16'hFFFF, 1'b1);
        chk("gap_c_count", 32'(count), 32'd16);
        chk("gap_c_seqerr", 32'(seq_err), 32'd0);
        chk("gap_c_locked", 32'(locked), 32'd1);
        chk("gap_c_errcnt", 32'(err_cnt), 32'(exp_err(3)));

        // Asynchronous reset between edges while locked.
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Saturation of the error counter.
        for (int k = 0; k < 300; k++) begin
            step(16'h0005, 1'b1);
        end
        chk("sat_illegal", 32'(illegal), 32'd1);
        chk("sat_errcnt", 32'(err_cnt), 32'(exp_err(255)));
        chk("sat_locked", 32'(locked), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
